stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Two-button user controller that sequences the stopwatch counter. It debounces the raw start/stop and lap/reset buttons and runs a four-state FSM. It drives the stopwatch's single-cycle start/pause/restart strobes and holds a lap value for a frozen display. It sits between the board push-buttons and the stopwatch datapath, and feeds the display path.

Parameters:
CNT_W, 32, width of stopwatch count and display
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a button level change (>=2)
AUTOSTOP_LIMIT, 32'hFFFF_FFF0, count threshold for auto-pause (used only with optional feature)

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
btn_ss  in  1  raw start/stop button, active-high, asynchronous, bouncy
btn_lr  in  1  raw lap/reset button, active-high, asynchronous, bouncy
count_in  in  CNT_W  live count from stopwatch
sw_start  out  1  one-cycle strobe to stopwatch start
sw_pause  out  1  one-cycle strobe to stopwatch pause
sw_restart  out  1  one-cycle strobe to stopwatch restart
display  out  CNT_W  value to show
lap_valid  out  1  high while display is frozen on a lap
state_o  out  2  FSM state (IDLE=0, RUN=1, LAP=2, PAUSED=3)
at_limit  out  1  auto-stop flag (tied 0 without optional feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; sw_* = 0; lap_reg = 0; sync flops, debounced levels and counters = 0; at_limit = 0.
- Power-on clear: sw_restart high for exactly one cycle on the first posedge after rst_n deasserts. Same after a mid-operation reset.
- Debounce, per button:
  - 2-flop synchroniser, then counter.
  - The counter increments each cycle the synced level differs from the debounced level. It clears whenever they match.
  - At DEBOUNCE_CYCLES the debounced level takes the synced level.
  - Press event = debounced rising edge, one cycle. Release generates nothing. A bounce shorter than DEBOUNCE_CYCLES produces no event.
- Latency: raw edge sampled at posedge k, then stable, gives the strobe high after posedge k+DEBOUNCE_CYCLES+2.
- Strobes are registered, mutually exclusive, and exactly one cycle wide.
- FSM, evaluated on press events only:
  - IDLE: ss -> RUN with sw_start. lr ignored.
  - RUN: ss -> PAUSED with sw_pause. lr -> LAP, lap_reg <= count_in.
  - LAP: ss -> PAUSED with sw_pause; freeze released. lr -> RUN; freeze released, no strobe.
  - PAUSED: ss -> RUN with sw_start. lr -> IDLE with sw_restart; lap_reg <= 0.
- Simultaneous ss and lr events in one cycle: ss wins, lr is dropped.
- Output mux (combinational, 0 latency):
  - display = lap_reg in LAP, else count_in.
  - lap_valid = (state == LAP).
- No wrap handling: count_in wrap is the stopwatch's concern, and display passes it through unchanged.
- Held button: one event per press. Re-arm requires the debounced level to return to 0.

Optional Feature:
Macro STOPWATCH_CTRL_AUTOSTOP_EN.
- Defined:
  - In RUN or LAP, count_in >= AUTOSTOP_LIMIT forces PAUSED with sw_pause (priority over button events that cycle).
  - at_limit is set and stays high until PAUSED is left.
  - Stopwatch overshoot of up to 2 counts past the limit is accepted.
  - In PAUSED with at_limit=1, an ss event is ignored; only lr (-> IDLE) is honoured.
- Undefined: no comparator; at_limit tied 0; AUTOSTOP_LIMIT unused.

Decomposition:
- Package stopwatch_pkg:
  - sw_state_e enum (IDLE, RUN, LAP, PAUSED; 2-bit encoding as above)
  - localparam default CNT_W
- Sub-module btn_debounce (synchroniser + counter + rising-edge pulse; params DEBOUNCE_CYCLES), instantiated once per button.

Test Plan:
- Release reset, no buttons -> sw_restart high exactly 1 cycle at posedge 1; state_o=0; display=count_in.
- DEBOUNCE_CYCLES=4; btn_ss rises at posedge 10, held 20 cycles -> sw_start single pulse after posedge 16; state_o=1; no further strobes while held.
- btn_ss toggles 1-0-1-0 every 2 cycles, then stays 0 -> no strobe, state unchanged.
- RUN, count_in=1234, lr press -> state_o=2, lap_valid=1, display=1234 while count_in advances. Second lr press -> state_o=1, display live.
- PAUSED: ss and lr debounced events in the same cycle -> sw_start only, state_o=1. Then ss -> PAUSED; lr -> sw_restart, state_o=0, lap_reg=0.
- With STOPWATCH_CTRL_AUTOSTOP_EN, AUTOSTOP_LIMIT=100, RUN -> count_in reaches 100 -> sw_pause pulse, state_o=3, at_limit=1. ss is ignored; lr -> IDLE, at_limit=0. Assert rst_n low mid-RUN -> outputs zero at once.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch button controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } sw_state_e;

    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, count and control/display signals between the board side and the controller.
interface stopwatch_ctrl_if
    import stopwatch_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    logic             btn_ss;
    logic             btn_lr;
    logic [CNT_W-1:0] count_in;
    logic             sw_start;
    logic             sw_pause;
    logic             sw_restart;
    logic [CNT_W-1:0] display;
    logic             lap_valid;
    logic [1:0]       state_o;
    logic             at_limit;

    modport master (
        output btn_ss, btn_lr, count_in,
        input  sw_start, sw_pause, sw_restart, display, lap_valid, state_o, at_limit
    );

    modport slave (
        input  btn_ss, btn_lr, count_in,
        output sw_start, sw_pause, sw_restart, display, lap_valid, state_o, at_limit
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and one-cycle press pulse for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                // This is the DEBOUNCE_CYCLES-th differing sample: accept the new level.
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch controller: debounce, four-state FSM, strobes and lap freeze.
// Optional auto-pause at AUTOSTOP_LIMIT is enabled by defining STOPWATCH_CTRL_AUTOSTOP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int               CNT_W           = DEFAULT_CNT_W,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [CNT_W-1:0] AUTOSTOP_LIMIT  = CNT_W'(32'hFFFF_FFF0)
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  bus
);

    logic [1:0]       w_raw;
    logic [1:0]       w_press;
    logic             w_ss_ok;
    logic             w_limit_hit;

    sw_state_e        r_state;
    logic             r_start;
    logic             r_pause;
    logic             r_restart;
    logic             r_at_limit;
    logic             r_por;
    logic [CNT_W-1:0] r_lap;

    // Index 0 is start/stop, index 1 is lap/reset.
    assign w_raw = {bus.btn_lr, bus.btn_ss};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_btn   (w_raw[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    assign w_limit_hit = ((r_state == RUN) || (r_state == LAP)) &&
                         (bus.count_in >= AUTOSTOP_LIMIT);
`else
    logic w_unused_limit;
    assign w_unused_limit = ^AUTOSTOP_LIMIT;
    assign w_limit_hit    = 1'b0;
`endif

    // After an auto-pause only lap/reset may leave PAUSED.
    assign w_ss_ok = w_press[0] && !((r_state == PAUSED) && r_at_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_pause    <= 1'b0;
            r_restart  <= 1'b0;
            r_at_limit <= 1'b0;
            r_por      <= 1'b1;
            r_lap      <= '0;
        end else begin
            r_start   <= 1'b0;
            r_pause   <= 1'b0;
            r_restart <= 1'b0;
            if (r_por) begin
                r_por     <= 1'b0;
                r_restart <= 1'b1;
            end else if (w_limit_hit) begin
                r_state    <= PAUSED;
                r_pause    <= 1'b1;
                r_at_limit <= 1'b1;
            end else if (w_ss_ok) begin
                case (r_state)
                    IDLE: begin
                        r_state <= RUN;
                        r_start <= 1'b1;
                    end
                    RUN, LAP: begin
                        r_state <= PAUSED;
                        r_pause <= 1'b1;
                    end
                    default: begin
                        r_state    <= RUN;
                        r_start    <= 1'b1;
                        r_at_limit <= 1'b0;
                    end
                endcase
            end else if (w_press[1]) begin
                case (r_state)
                    RUN: begin
                        r_state <= LAP;
                        r_lap   <= bus.count_in;
                    end
                    LAP: begin
                        r_state <= RUN;
                    end
                    PAUSED: begin
                        r_state    <= IDLE;
                        r_restart  <= 1'b1;
                        r_lap      <= '0;
                        r_at_limit <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sw_start   = r_start;
    assign bus.sw_pause   = r_pause;
    assign bus.sw_restart = r_restart;
    assign bus.state_o    = r_state;
    assign bus.at_limit   = r_at_limit;
    assign bus.lap_valid  = (r_state == LAP);
    assign bus.display    = (r_state == LAP) ? r_lap : bus.count_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus random bench for stopwatch_ctrl against a window-based behavioural model.
module tb_stopwatch_ctrl;

    localparam int          CNT_W = 32;
    localparam int          DB    = 4;
    localparam logic [31:0] LIMIT = 32'd100;
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    localparam bit          AUTOSTOP = 1'b1;
    localparam logic [31:0] CBASE    = 32'd20;
`else
    localparam bit          AUTOSTOP = 1'b0;
    localparam logic [31:0] CBASE    = 32'd1234;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    stopwatch_ctrl #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DB),
        .AUTOSTOP_LIMIT  (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit adv        = 1'b0;

    // Reference model state: 0=IDLE 1=RUN 2=LAP 3=PAUSED
    int          m_state;
    bit          m_start, m_pause, m_restart, m_lim, m_por;
    logic [31:0] m_lap;
    bit [15:0]   hist_ss, hist_lr;
    bit          db_ss, db_lr, ev_ss, ev_lr;
    int          next_ss_tbl [4] = '{1, 3, 3, 1};
    int          next_lr_tbl [4] = '{0, 2, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_start = 0; m_pause = 0; m_restart = 0; m_lim = 0; m_por = 1;
        m_lap = '0; hist_ss = '0; hist_lr = '0;
        db_ss = 0; db_lr = 0; ev_ss = 0; ev_lr = 0;
    endtask

    // A level change is accepted once the last DB synchronised samples all disagree with it.
    function automatic bit window_flip(input bit [15:0] h, input bit db);
        for (int k = 2; k < DB + 2; k++)
            if (h[k] == db) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        m_start = 0; m_pause = 0; m_restart = 0;
        if (m_por) begin
            m_restart = 1; m_por = 0;
        end else if (AUTOSTOP && (m_state == 1 || m_state == 2) && bus.count_in >= LIMIT) begin
            m_state = 3; m_pause = 1; m_lim = 1;
        end else if (ev_ss && !(m_state == 3 && m_lim)) begin
            if (m_state == 0 || m_state == 3) m_start = 1; else m_pause = 1;
            m_state = next_ss_tbl[m_state];
        end else if (ev_lr) begin
            if (m_state == 1) m_lap = bus.count_in;
            if (m_state == 3) begin m_restart = 1; m_lap = '0; end
            m_state = next_lr_tbl[m_state];
        end
        if (m_state != 3) m_lim = 0;
        hist_ss = {hist_ss[14:0], bus.btn_ss};
        hist_lr = {hist_lr[14:0], bus.btn_lr};
        ev_ss = 0; ev_lr = 0;
        if (window_flip(hist_ss, db_ss)) begin db_ss = ~db_ss; ev_ss = db_ss; end
        if (window_flip(hist_lr, db_lr)) begin db_lr = ~db_lr; ev_lr = db_lr; end
    endtask

    task automatic check_all();
        check("state", 32'(bus.state_o), 32'(m_state));
        check("sw_start", 32'(bus.sw_start), 32'(m_start));
        check("sw_pause", 32'(bus.sw_pause), 32'(m_pause));
        check("sw_restart", 32'(bus.sw_restart), 32'(m_restart));
        check("lap_valid", 32'(bus.lap_valid), 32'(m_state == 2));
        check("display", bus.display, (m_state == 2) ? m_lap : bus.count_in);
        check("at_limit", 32'(bus.at_limit), 32'(m_lim));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            check_all();
            if (adv) bus.count_in = bus.count_in + 32'd1;
        end
    endtask

    task automatic press(input bit lr, input int hold);
        if (lr) bus.btn_lr = 1'b1; else bus.btn_ss = 1'b1;
        run(hold);
        if (lr) bus.btn_lr = 1'b0; else bus.btn_ss = 1'b0;
        run(DB + 4);
    endtask

    task automatic check_reset_zero();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_strobes", {29'd0, bus.sw_start, bus.sw_pause, bus.sw_restart}, 32'd0);
        check("rst_lap_valid", 32'(bus.lap_valid), 32'd0);
        check("rst_at_limit", 32'(bus.at_limit), 32'd0);
        check("rst_display", bus.display, bus.count_in);
    endtask

    initial begin
        bus.btn_ss = 1'b0; bus.btn_lr = 1'b0; bus.count_in = CBASE;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_zero();
        rst_n = 1'b1;
        run(1);
        check("por_restart", 32'(bus.sw_restart), 32'd1);
        run(4);

        // Clean start press: strobe appears after posedge k+DB+2.
        bus.btn_ss = 1'b1;
        run(DB + 2);
        check("latency_early", 32'(bus.sw_start), 32'd0);
        run(1);
        check("latency_start", 32'(bus.sw_start), 32'd1);
        check("latency_state", 32'(bus.state_o), 32'd1);
        run(14);
        bus.btn_ss = 1'b0;
        run(DB + 4);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 2; i++) begin
            bus.btn_ss = 1'b1; run(2);
            bus.btn_ss = 1'b0; run(2);
        end
        run(10);
        check("bounce_state", 32'(bus.state_o), 32'd1);

        // Lap freeze while count advances, then release.
        adv = 1'b1;
        press(1'b1, 6);
        check("lap_state", 32'(bus.state_o), 32'd2);
        press(1'b1, 6);
        check("lap_exit_state", 32'(bus.state_o), 32'd1);
        adv = 1'b0;

        // RUN -> PAUSED, then simultaneous presses: start/stop wins.
        press(1'b0, 6);
        check("pause_state", 32'(bus.state_o), 32'd3);
        bus.btn_ss = 1'b1; bus.btn_lr = 1'b1;
        run(DB + 3);
        check("simul_state", 32'(bus.state_o), 32'd1);
        bus.btn_ss = 1'b0; bus.btn_lr = 1'b0;
        run(DB + 4);
        press(1'b0, 6);
        press(1'b1, 6);
        check("reset_to_idle", 32'(bus.state_o), 32'd0);

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        press(1'b0, 6);
        bus.count_in = 32'd95;
        adv = 1'b1;
        run(10);
        adv = 1'b0;
        check("auto_state", 32'(bus.state_o), 32'd3);
        check("auto_flag", 32'(bus.at_limit), 32'd1);
        press(1'b0, 6);
        check("auto_ss_ignored", 32'(bus.state_o), 32'd3);
        press(1'b1, 6);
        check("auto_lr_idle", 32'(bus.state_o), 32'd0);
        check("auto_flag_clr", 32'(bus.at_limit), 32'd0);
        bus.count_in = CBASE;
`endif

        // Random bouncy buttons and a wandering count.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) bus.btn_ss = ~bus.btn_ss;
            if ($urandom_range(0, 11) == 0) bus.btn_lr = ~bus.btn_lr;
            if ($urandom_range(0, 199) == 0)
                bus.count_in = $urandom_range(0, AUTOSTOP ? 90 : 100000);
            else
                bus.count_in = bus.count_in + $urandom_range(0, 2);
            run(1);
        end
        bus.btn_ss = 1'b0; bus.btn_lr = 1'b0;
        bus.count_in = CBASE;
        run(DB + 4);

        // Reset mid-RUN: outputs clear immediately, restart follows release.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(4);
        press(1'b0, 6);
        check("midrst_run", 32'(bus.state_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_zero();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(1);
        check("midrst_restart", 32'(bus.sw_restart), 32'd1);
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
